iiitb_apb: RTL and testbench

//  Self-contained APB2 subsystem: one APB master FSM driving two internal 256x8 register-file slaves.
//  A user-side request interface (transfer, READ_WRITE, addresses, write data) is converted into

---
 rtl/iiitb_apb.sv | 171 +++++++++++++++++
 tb/tb_iiitb_apb.sv | 247 ++++++++++++++++++++++++
 2 files changed

// File: rtl/iiitb_apb.sv
// APB2 subsystem: one master FSM that turns user requests into SETUP/ACCESS cycles,
// driving two zero-wait-state register-file slaves selected by PADDR[ADDR_W].

module ApbRegSlave #(
  parameter int ADDR_W = 8,
  parameter int DATA_W = 8
) (
  input  logic              pclk_i,
  input  logic              presetn_i,
  input  logic              psel_i,
  input  logic              penable_i,
  input  logic              pwrite_i,
  input  logic [ADDR_W-1:0] paddr_i,
  input  logic [DATA_W-1:0] pwdata_i,
  output logic              pready_o,
  output logic [DATA_W-1:0] prdata_o,
  output logic              pslverr_o
);

  localparam int DEPTH = 2 ** ADDR_W;

  // Storage is power-up initialised and deliberately untouched by PRESETn.
  logic [DATA_W-1:0] mem_q   [DEPTH] = '{default: '0};
  logic [DEPTH-1:0]  valid_q         = '0;

  logic access;
  assign access = psel_i & penable_i;

  // presetn_i gates the write so a reset landing on the ACCESS edge aborts it.
  always_ff @(posedge pclk_i) begin
    if (presetn_i && access && pwrite_i) begin
      mem_q[paddr_i]   <= pwdata_i;
      valid_q[paddr_i] <= 1'b1;
    end
  end

  assign pready_o  = access;
  assign prdata_o  = valid_q[paddr_i] ? mem_q[paddr_i] : '0;
  assign pslverr_o = access & ~pwrite_i & ~valid_q[paddr_i];

endmodule

module iiitb_apb #(
  parameter int ADDR_W = 8,
  parameter int DATA_W = 8
) (
  input  logic              PCLK,
  input  logic              PRESETn,
  input  logic              transfer,
  input  logic              READ_WRITE,
  input  logic [ADDR_W:0]   apb_write_paddr,
  input  logic [DATA_W-1:0] apb_write_data,
  input  logic [ADDR_W:0]   apb_read_paddr,
  output logic              PSLVERR,
  output logic [DATA_W-1:0] apb_read_data_out
);

  typedef enum logic [1:0] {
    IDLE,
    SETUP,
    ACCESS
  } state_e;

  state_e              state_q;
  logic                psel_q;
  logic                penable_q;
  logic                pwrite_q;
  logic [ADDR_W:0]     paddr_q;
  logic [DATA_W-1:0]   pwdata_q;
  logic                pslverr_q;
  logic [DATA_W-1:0]   rdata_q;

  logic [ADDR_W:0]     paddr_d;
  logic                psel1, psel2;
  logic                pready1, pready2, pready;
  logic                slverr1, slverr2, slverr;
  logic [DATA_W-1:0]   prdata1, prdata2, prdata;

  assign paddr_d = READ_WRITE ? apb_read_paddr : apb_write_paddr;

  assign psel1 = psel_q & ~paddr_q[ADDR_W];
  assign psel2 = psel_q &  paddr_q[ADDR_W];

  assign pready = paddr_q[ADDR_W] ? pready2 : pready1;
  assign slverr = paddr_q[ADDR_W] ? slverr2 : slverr1;
  assign prdata = paddr_q[ADDR_W] ? prdata2 : prdata1;

  // Bus controls, captured address/data and user-side results all update here;
  // every edge entering SETUP samples a fresh request.
  always_ff @(posedge PCLK) begin
    if (!PRESETn) begin
      state_q   <= IDLE;
      psel_q    <= 1'b0;
      penable_q <= 1'b0;
      pwrite_q  <= 1'b0;
      paddr_q   <= '0;
      pwdata_q  <= '0;
      pslverr_q <= 1'b0;
      rdata_q   <= '0;
    end else begin
      unique case (state_q)
        IDLE: begin
          if (transfer) begin
            state_q   <= SETUP;
            psel_q    <= 1'b1;
            penable_q <= 1'b0;
            paddr_q   <= paddr_d;
            pwdata_q  <= apb_write_data;
            pwrite_q  <= ~READ_WRITE;
          end
        end
        SETUP: begin
          state_q   <= ACCESS;
          penable_q <= 1'b1;
        end
        ACCESS: begin
          if (pready) begin
            pslverr_q <= slverr;
            if (!pwrite_q) rdata_q <= prdata;
            if (transfer) begin
              state_q   <= SETUP;
              penable_q <= 1'b0;
              paddr_q   <= paddr_d;
              pwdata_q  <= apb_write_data;
              pwrite_q  <= ~READ_WRITE;
            end else begin
              state_q   <= IDLE;
              psel_q    <= 1'b0;
              penable_q <= 1'b0;
            end
          end
        end
        default: begin
          state_q   <= IDLE;
          psel_q    <= 1'b0;
          penable_q <= 1'b0;
        end
      endcase
    end
  end

  ApbRegSlave #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) u_slave1 (
    .pclk_i    (PCLK),
    .presetn_i (PRESETn),
    .psel_i    (psel1),
    .penable_i (penable_q),
    .pwrite_i  (pwrite_q),
    .paddr_i   (paddr_q[ADDR_W-1:0]),
    .pwdata_i  (pwdata_q),
    .pready_o  (pready1),
    .prdata_o  (prdata1),
    .pslverr_o (slverr1)
  );

  ApbRegSlave #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) u_slave2 (
    .pclk_i    (PCLK),
    .presetn_i (PRESETn),
    .psel_i    (psel2),
    .penable_i (penable_q),
    .pwrite_i  (pwrite_q),
    .paddr_i   (paddr_q[ADDR_W-1:0]),
    .pwdata_i  (pwdata_q),
    .pready_o  (pready2),
    .prdata_o  (prdata2),
    .pslverr_o (slverr2)
  );

  assign PSLVERR           = pslverr_q;
  assign apb_read_data_out = rdata_q;

endmodule

// File: tb/tb_iiitb_apb.sv
// Directed self-checking bench for iiitb_apb: writes, reads, error reads, reset
// retention/abort, idle hold and transfer deassertion during SETUP.

module tb_iiitb_apb;

  logic       PCLK = 1'b0;
  logic       PRESETn = 1'b0;
  logic       transfer = 1'b0;
  logic       READ_WRITE = 1'b0;
  logic [8:0] apb_write_paddr = '0;
  logic [7:0] apb_write_data = '0;
  logic [8:0] apb_read_paddr = '0;
  logic       PSLVERR;
  logic [7:0] apb_read_data_out;

  int passCount = 0;
  int checkCount = 0;

  iiitb_apb dut (
    .PCLK              (PCLK),
    .PRESETn           (PRESETn),
    .transfer          (transfer),
    .READ_WRITE        (READ_WRITE),
    .apb_write_paddr   (apb_write_paddr),
    .apb_write_data    (apb_write_data),
    .apb_read_paddr    (apb_read_paddr),
    .PSLVERR           (PSLVERR),
    .apb_read_data_out (apb_read_data_out)
  );

  always #5 PCLK = ~PCLK;

  // Present a request and step through the edge that captures it (enters SETUP);
  // that same edge completes any previous ACCESS.
  task automatic captureEdge(input logic rw, input logic [8:0] wa, input logic [7:0] wd,
                             input logic [8:0] ra);
    transfer        = 1'b1;
    READ_WRITE      = rw;
    apb_write_paddr = wa;
    apb_write_data  = wd;
    apb_read_paddr  = ra;
    @(posedge PCLK); #1;
  endtask

  task automatic accessEdge();
    @(posedge PCLK); #1;
  endtask

  task automatic endSeq();
    transfer = 1'b0;
    @(posedge PCLK); #1;
  endtask

  task automatic test_reset();
    PRESETn = 1'b0;
    transfer = 1'b0;
    repeat (2) @(posedge PCLK);
    #1;
    PRESETn = 1'b1;
    checkCount++;
    if (PSLVERR !== 1'b0) $display("[TB] FAIL reset_pslverr: got %b expected 0", PSLVERR);
    else passCount++;
    checkCount++;
    if (apb_read_data_out !== 8'h00)
      $display("[TB] FAIL reset_rdata: got %h expected 00", apb_read_data_out);
    else passCount++;
    checkCount++;
    if (dut.psel_q !== 1'b0 || dut.penable_q !== 1'b0)
      $display("[TB] FAIL reset_bus: got psel=%b penable=%b expected 0/0", dut.psel_q, dut.penable_q);
    else passCount++;
  endtask

  task automatic test_write_slave1();
    for (int i = 0; i < 8; i++) begin
      captureEdge(1'b0, {1'b0, 8'(i)}, 8'(2 * i), 9'd0);
      accessEdge();
    end
    endSeq();
    checkCount++;
    if (PSLVERR !== 1'b0) $display("[TB] FAIL wr_s1_pslverr: got %b expected 0", PSLVERR);
    else passCount++;
    checkCount++;
    if (dut.psel_q !== 1'b0) $display("[TB] FAIL wr_s1_idle: got psel=%b expected 0", dut.psel_q);
    else passCount++;
  endtask

  task automatic test_write_slave2();
    for (int i = 0; i < 8; i++) begin
      captureEdge(1'b0, {1'b1, 8'(i)}, 8'(i), 9'd0);
      accessEdge();
    end
    endSeq();
    checkCount++;
    if (PSLVERR !== 1'b0) $display("[TB] FAIL wr_s2_pslverr: got %b expected 0", PSLVERR);
    else passCount++;
  endtask

  task automatic test_truncation();
    logic [9:0] wide;
    wide = 10'd526;
    captureEdge(1'b0, wide[8:0], 8'd9, 9'd0);
    accessEdge();
    captureEdge(1'b0, 9'd22, 8'd35, 9'd0);
    accessEdge();
    endSeq();
    checkCount++;
    if (PSLVERR !== 1'b0) $display("[TB] FAIL trunc_pslverr: got %b expected 0", PSLVERR);
    else passCount++;
  endtask

  task automatic test_read_after_reset();
    PRESETn = 1'b0;
    @(posedge PCLK); #1;
    PRESETn = 1'b1;
    for (int i = 0; i < 8; i++) begin
      captureEdge(1'b1, 9'd0, 8'd0, {1'b0, 8'(i)});
      if (i > 0) begin
        checkCount++;
        if (apb_read_data_out !== 8'(2 * (i - 1)) || PSLVERR !== 1'b0)
          $display("[TB] FAIL rd_s1_%0d: got data=%h err=%b expected data=%h err=0",
                   i - 1, apb_read_data_out, PSLVERR, 8'(2 * (i - 1)));
        else passCount++;
      end
      accessEdge();
    end
    endSeq();
    checkCount++;
    if (apb_read_data_out !== 8'd14 || PSLVERR !== 1'b0)
      $display("[TB] FAIL rd_s1_7: got data=%h err=%b expected data=0e err=0",
               apb_read_data_out, PSLVERR);
    else passCount++;
  endtask

  task automatic test_read_slave2();
    logic [8:0] raddr [11];
    logic [7:0] expData [11];
    logic       expErr [11];
    for (int i = 0; i < 8; i++) begin
      raddr[i] = {1'b1, 8'(i)};
      expData[i] = 8'(i);
      expErr[i] = 1'b0;
    end
    raddr[8]  = 9'd45;  expData[8]  = 8'h00; expErr[8]  = 1'b1;
    raddr[9]  = 9'h00E; expData[9]  = 8'h09; expErr[9]  = 1'b0;
    raddr[10] = 9'd22;  expData[10] = 8'h23; expErr[10] = 1'b0;
    for (int i = 0; i < 11; i++) begin
      captureEdge(1'b1, 9'h1FF, 8'hAA, raddr[i]);
      if (i > 0) begin
        checkCount++;
        if (apb_read_data_out !== expData[i-1] || PSLVERR !== expErr[i-1])
          $display("[TB] FAIL rd_mix_%0d: got data=%h err=%b expected data=%h err=%b",
                   i - 1, apb_read_data_out, PSLVERR, expData[i-1], expErr[i-1]);
        else passCount++;
      end
      accessEdge();
    end
    endSeq();
    checkCount++;
    if (apb_read_data_out !== 8'h23 || PSLVERR !== 1'b0)
      $display("[TB] FAIL rd_mix_10: got data=%h err=%b expected data=23 err=0",
               apb_read_data_out, PSLVERR);
    else passCount++;
  endtask

  task automatic test_idle_hold();
    captureEdge(1'b1, 9'd0, 8'd0, 9'd45);
    accessEdge();
    endSeq();
    for (int i = 0; i < 5; i++) begin
      READ_WRITE = ~READ_WRITE;
      apb_read_paddr = 9'(i);
      apb_write_paddr = 9'(i + 3);
      @(posedge PCLK); #1;
    end
    checkCount++;
    if (apb_read_data_out !== 8'h00 || PSLVERR !== 1'b1)
      $display("[TB] FAIL idle_hold: got data=%h err=%b expected data=00 err=1",
               apb_read_data_out, PSLVERR);
    else passCount++;
    checkCount++;
    if (dut.psel_q !== 1'b0) $display("[TB] FAIL idle_psel: got %b expected 0", dut.psel_q);
    else passCount++;
  endtask

  task automatic test_reset_abort();
    captureEdge(1'b0, 9'd100, 8'h55, 9'd0);
    accessEdge();
    PRESETn = 1'b0;
    transfer = 1'b0;
    @(posedge PCLK); #1;
    PRESETn = 1'b1;
    checkCount++;
    if (PSLVERR !== 1'b0 || dut.psel_q !== 1'b0)
      $display("[TB] FAIL abort_reset: got err=%b psel=%b expected 0/0", PSLVERR, dut.psel_q);
    else passCount++;
    captureEdge(1'b1, 9'd0, 8'd0, 9'd100);
    accessEdge();
    endSeq();
    checkCount++;
    if (apb_read_data_out !== 8'h00 || PSLVERR !== 1'b1)
      $display("[TB] FAIL abort_nowrite: got data=%h err=%b expected data=00 err=1",
               apb_read_data_out, PSLVERR);
    else passCount++;
  endtask

  task automatic test_drop_in_setup();
    captureEdge(1'b0, 9'h13C, 8'h77, 9'd0);
    transfer = 1'b0;
    accessEdge();
    checkCount++;
    if (dut.psel_q !== 1'b1 || dut.penable_q !== 1'b1)
      $display("[TB] FAIL drop_access: got psel=%b penable=%b expected 1/1", dut.psel_q, dut.penable_q);
    else passCount++;
    @(posedge PCLK); #1;
    checkCount++;
    if (PSLVERR !== 1'b0 || dut.psel_q !== 1'b0)
      $display("[TB] FAIL drop_complete: got err=%b psel=%b expected 0/0", PSLVERR, dut.psel_q);
    else passCount++;
    @(posedge PCLK); #1;
    checkCount++;
    if (dut.psel_q !== 1'b0) $display("[TB] FAIL drop_stay_idle: got psel=%b expected 0", dut.psel_q);
    else passCount++;
    captureEdge(1'b1, 9'd0, 8'd0, 9'h13C);
    accessEdge();
    endSeq();
    checkCount++;
    if (apb_read_data_out !== 8'h77 || PSLVERR !== 1'b0)
      $display("[TB] FAIL drop_readback: got data=%h err=%b expected data=77 err=0",
               apb_read_data_out, PSLVERR);
    else passCount++;
  endtask

  initial begin
    test_reset();
    test_write_slave1();
    test_write_slave2();
    test_truncation();
    test_read_after_reset();
    test_read_slave2();
    test_idle_hold();
    test_reset_abort();
    test_drop_in_setup();
    $display("%0d/%0d checks passed", passCount, checkCount);
    $finish;
  end

endmodule
